// File: rtl/vga_console_m.sv
// Text console writer: turns a byte stream of characters and control codes
// into character/attribute cell writes for the VGA text memory, port A.
module vga_console_m #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60
) (
  input  logic        i_clk_25MHz,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_char,
  output logic        o_ready,
  input  logic [7:0]  i_attr,
  output logic [3:0]  o_vga_mem_we,
  output logic [11:0] o_vga_mem_waddr,
  output logic [31:0] o_vga_mem_wdata,
  output logic [6:0]  o_cursor_col,
  output logic [5:0]  o_cursor_row,
  output logic        o_busy
);

  localparam int unsigned ROW_WORDS    = COLS / 2;
  localparam int unsigned SCREEN_WORDS = ROWS * ROW_WORDS;
  localparam logic [11:0] LAST_WORD     = 12'(SCREEN_WORDS - 1);
  localparam logic [11:0] LAST_ROW_WORD = 12'(ROW_WORDS - 1);
  localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW      = 6'(ROWS - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] RST_ATTR = 8'h07;

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    IDLE      = 2'd1,
    CLEAR_ROW = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  attr_q, attr_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [3:0]  we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic [11:0] row_ext, row_base, wr_addr;
  logic [6:0]  col_m1, wr_col;
  logic [3:0]  wr_we;
  logic        accept;

  // Cell address of the cursor row (row*40 via shifts) and of the target column.
  always_comb begin
    row_ext  = 12'(row_q);
    row_base = (row_ext << 5) + (row_ext << 3);
    col_m1   = col_q - 7'd1;
    wr_col   = (i_char == CH_BS) ? col_m1 : col_q;
    wr_addr  = row_base + 12'(wr_col[6:1]);
    wr_we    = wr_col[0] ? 4'b1100 : 4'b0011;
    accept   = i_valid && (state_q == IDLE);
  end

  // Next-state, cursor and memory-write decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    attr_d  = attr_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = 4'h0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      CLEAR_ALL: begin
        we_d    = 4'hF;
        waddr_d = cnt_q;
        wdata_d = {attr_q, CH_SPACE, attr_q, CH_SPACE};
        if (cnt_q == LAST_WORD) begin
          state_d = IDLE;
          cnt_d   = 12'd0;
          col_d   = 7'd0;
          row_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      CLEAR_ROW: begin
        we_d    = 4'hF;
        waddr_d = row_base + cnt_q;
        wdata_d = {attr_q, CH_SPACE, attr_q, CH_SPACE};
        if (cnt_q == LAST_ROW_WORD) begin
          state_d = IDLE;
          cnt_d   = 12'd0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: begin
        if (accept) begin
          unique case (i_char)
            CH_LF: begin
              col_d = 7'd0;
              if (row_q < LAST_ROW) begin
                row_d = row_q + 6'd1;
              end else begin
                row_d   = 6'd0;
                attr_d  = i_attr;
                cnt_d   = 12'd0;
                state_d = CLEAR_ROW;
              end
            end
            CH_CR: col_d = 7'd0;
            CH_BS: begin
              if (col_q != 7'd0) begin
                col_d   = col_m1;
                we_d    = wr_we;
                waddr_d = wr_addr;
                wdata_d = {i_attr, CH_SPACE, i_attr, CH_SPACE};
              end
            end
            CH_FF: begin
              attr_d  = i_attr;
              cnt_d   = 12'd0;
              state_d = CLEAR_ALL;
            end
            default: begin
              we_d    = wr_we;
              waddr_d = wr_addr;
              wdata_d = {i_attr, i_char, i_attr, i_char};
              if (col_q == LAST_COL) begin
                col_d = 7'd0;
                if (row_q < LAST_ROW) begin
                  row_d = row_q + 6'd1;
                end else begin
                  row_d   = 6'd0;
                  attr_d  = i_attr;
                  cnt_d   = 12'd0;
                  state_d = CLEAR_ROW;
                end
              end else begin
                col_d = col_q + 7'd1;
              end
            end
          endcase
        end
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State, cursor and registered memory-port outputs.
  always_ff @(posedge i_clk_25MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLEAR_ALL;
      cnt_q   <= 12'd0;
      attr_q  <= RST_ATTR;
      col_q   <= 7'd0;
      row_q   <= 6'd0;
      we_q    <= 4'h0;
      waddr_q <= 12'd0;
      wdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      attr_q  <= attr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ready         = ready_q;
  assign o_busy          = busy_q;
  assign o_vga_mem_we    = we_q;
  assign o_vga_mem_waddr = waddr_q;
  assign o_vga_mem_wdata = wdata_q;
  assign o_cursor_col    = col_q;
  assign o_cursor_row    = row_q;

endmodule

// File: doc/vga_console_m.md
# vga_console_m

Text-console writer placed directly upstream of the VGA text driver. Accepts a byte stream of characters and control codes over a valid/ready handshake. Maintains an 80x60 cursor and writes character/attribute cells into port A of the VGA text memory (`o_vga_mem_*` connect 1:1 to the driver's `i_vga_mem_*`). Handles newline, carriage return, backspace, form feed (clear screen) and end-of-screen wrap with row clearing.

## Interface
- COLS, 80, text columns; must be even.
- ROWS, 60, text rows.
- i_clk_25MHz  in  1  clock, same domain as VGA memory port A.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  i_char valid.
- i_char  in  8  character or control code.
- o_ready  out  1  block can accept a byte this cycle.
- i_attr  in  8  {bg[3:0], fg[3:0]}; sampled when a byte is accepted and when a clear starts.
- o_vga_mem_we  out  4  byte write enables.
- o_vga_mem_waddr  out  12  word address.
- o_vga_mem_wdata  out  32  {bg1,fg1,char1,bg0,fg0,char0}.
- o_cursor_col  out  7  current cursor column, 0..COLS-1.
- o_cursor_row  out  6  current cursor row, 0..ROWS-1.
- o_busy  out  1  high in either clear state.

## Operation
- Memory map: cell (row,col) is in word `row*40 + col[6:1]`. Even col uses bytes 0-1 (we=4'b0011, data in [15:0]). Odd col uses bytes 2-3 (we=4'b1100, data in [31:16]). Each cell half is {bg,fg,char}. `row*40` is computed as `(row<<5)+(row<<3)` in 12 bits, with no multiplier. The maximum address is 2399.
- States: CLEAR_ALL, IDLE, CLEAR_ROW. o_ready = (state==IDLE).
- Reset: all outputs 0, cursor (0,0), state CLEAR_ALL, clear attribute 8'h07.
- CLEAR_ALL: writes words 0..2399, one per cycle, with we=4'hF and data {attr,8'h20,attr,8'h20}. After word 2399 it goes to IDLE with cursor (0,0).
- CLEAR_ROW: writes the 40 words of the cursor row with the same pattern, then goes to IDLE. The cursor does not change.
- IDLE, byte accepted (i_valid & o_ready):
  - 0x0A LF: col←0. If row<ROWS-1, row←row+1. Otherwise row←0 and go to CLEAR_ROW. No cell write.
  - 0x0D CR: col←0. No write.
  - 0x08 BS: if col>0, col←col-1 and write a space with i_attr at the new cell. At col 0 it is a no-op.
  - 0x0C FF: capture i_attr and go to CLEAR_ALL. The cursor goes to (0,0) when the clear completes.
  - Any other value is printable: write {i_attr,i_char} at the cursor, then advance. If col=COLS-1, advance acts as LF, including the wrap and CLEAR_ROW at the last row.
- Wrap rule: the screen never scrolls. Output continues at row 0 after that row has been cleared.
- A reset mid-clear aborts the clear and restarts CLEAR_ALL from word 0.
- In IDLE with no accepted byte, we=0. waddr and wdata hold their last values.

## Timing
- All memory outputs are registered. A byte accepted at edge N produces one write cycle: we, waddr and wdata are valid after edge N, for exactly one cycle.
- The cursor outputs update at the same edge N.
- Back-to-back printable bytes are accepted every cycle, giving one write per cycle.
- The first clear write is driven in the cycle after the edge that enters a clear state. For LF/wrap, that edge is N.
- A clear runs 40 cycles (CLEAR_ROW) or 2400 cycles (CLEAR_ALL). o_ready is low for exactly that many cycles, then returns high.
- After reset release, o_ready rises after 2400 clock edges.
- i_char and i_attr must be stable only in the accepting cycle.

## Test plan
- Reset, then wait: exactly 2400 writes, addresses 0..2399, each with we=F and wdata=32'h0720_0720. o_ready then goes high and the cursor reads (0,0).
- With i_attr=8'h1E, send 'A' then 'B': write addr 0, we=3, wdata[15:0]=16'h1E41. Then write addr 0, we=C, wdata[31:16]=16'h1E42. Cursor ends at (2,0).
- Send 79 spaces, then 'X', then 'Y': 'X' goes to addr 39 with we=C. 'Y' goes to addr 40 with we=3. Cursor ends at (1,1).
- Send 59 LFs, then one more LF: the cursor ends at row 59, then wraps to (0,0). o_ready is low for 40 cycles while addresses 0..39 are written with spaces.
- At (5,3), send BS: a space is written to cell (4,3), i.e. addr 122 with we=3, and the cursor is (4,3). A BS at col 0 produces no write.
- Send FF with i_attr=8'h40 and assert reset at clear word 1000: the clear restarts from word 0 with attr 07. It completes in 2400 cycles and the cursor is (0,0).
